// File: rtl/stack_ram.sv
// Word store for the stack calculator's data bus. After reset it scrubs every
// word to FILL, then serves combinational reads and clocked writes with an occupancy bitmap.
module stack_ram #(
    parameter int            DEPTH = 128,
    parameter int            AW    = 7,
    parameter int            DW    = 8,
    parameter logic [DW-1:0] FILL  = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] address,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          rd_valid,
    output logic [AW:0]   used,
    output logic          busy
);

    typedef enum logic {
        INIT,
        READY
    } state_t;

    localparam logic [AW-1:0] SCNT_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] SCNT_ONE  = AW'(1);
    localparam logic [AW:0]   USED_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   USED_MAX  = (AW+1)'(DEPTH);

    state_t         state_q, state_d;
    logic [AW-1:0]  scnt_q, scnt_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW:0]    used_q, used_d;
    logic [DW-1:0]  mem_q [DEPTH];

    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic           data_nz;

    assign data_nz = (data_in != '0);

    // One shared write port: the scrub owns it in INIT, the controller in READY.
    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        valid_d   = valid_q;
        used_d    = used_q;
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = data_in;
        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = scnt_q;
                mem_wdata = FILL;
                scnt_d    = scnt_q + SCNT_ONE;
                if (scnt_q == SCNT_LAST) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (cs && we) begin
                    mem_we = 1'b1;
                    // A pop writes zero, which frees the slot; overwrites keep the count.
                    if (!valid_q[address] && data_nz) begin
                        valid_d[address] = 1'b1;
                        used_d           = used_q + USED_ONE;
                    end else if (valid_q[address] && !data_nz) begin
                        valid_d[address] = 1'b0;
                        used_d           = used_q - USED_ONE;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            scnt_q  <= '0;
            valid_q <= '0;
            used_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            valid_q <= valid_d;
            used_q  <= used_d;
        end
    end

    // Array contents survive reset; the scrub is what makes them defined.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    assign busy     = (state_q == INIT);
    assign data_out = busy ? '0 : mem_q[address];
    assign rd_valid = valid_q[address];
    assign used     = used_q;

    assert property (@(posedge clk) disable iff (!reset) used_q <= USED_MAX);

endmodule

// File: tb/tb_stack_ram.sv
// Randomized bench for stack_ram against a word-array reference model in which
// a word counts as occupied exactly when it holds a nonzero value since the scrub.
module tb_stack_ram;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
    localparam int DW    = 8;

    logic          clk;
    logic          reset;
    logic          cs;
    logic          we;
    logic [AW-1:0] address;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic [AW:0]   used;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_mem [DEPTH];

    stack_ram #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .FILL(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .we       (we),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid),
        .used     (used),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_mem[i] != 8'h00) n++;
        end
        return n;
    endfunction

    // Releases reset and counts edges until busy falls; optionally tries
    // a write of 77 to address 10 on scrub edges 5 and DEPTH.
    task automatic scrub(input bit inject);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        while (!done && n < 2 * DEPTH + 8) begin
            @(posedge clk);
            #1;
            n++;
            cs = 1'b0;
            we = 1'b0;
            if (!busy) begin
                done = 1'b1;
            end else if (inject && (n == 4 || n == DEPTH - 1)) begin
                address = 7'h10;
                data_in = 8'h77;
                cs      = 1'b1;
                we      = 1'b1;
            end
        end
        cs = 1'b0;
        we = 1'b0;
        check("scrub_len", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic c, input logic w);
        address = a;
        data_in = d;
        cs      = c;
        we      = w;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
        if (c && w) m_mem[a] = d;
    endtask

    task automatic rd_check(input string tag, input logic [AW-1:0] a);
        address = a;
        #1;
        check({tag, "_data"}, data_out, m_mem[a]);
        check({tag, "_rdv"}, rd_valid, m_mem[a] != 8'h00);
    endtask

    task automatic all_zero(input string tag);
        for (int i = 0; i < DEPTH; i++) rd_check(tag, AW'(i));
        check({tag, "_used"}, used, 0);
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic c;
        logic w;

        reset   = 1'b0;
        cs      = 1'b0;
        we      = 1'b0;
        address = '0;
        data_in = '0;
        #2;
        check("rst_busy", busy, 1);
        check("rst_used", used, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_dout", data_out, 0);
        #20;

        // Fill the array with garbage, then reset and scrub with blocked writes.
        scrub(1'b0);
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom_range(1, 255)), 1'b1, 1'b1);
        check("full_used", used, DEPTH);
        @(negedge clk);
        reset = 1'b0;
        #12;
        scrub(1'b1);
        rd_check("busy_drop", 7'h10);
        all_zero("scrub");

        // Push sequence
        wr(7'h7F, 8'h05, 1'b1, 1'b1);
        wr(7'h7E, 8'h0A, 1'b1, 1'b1);
        wr(7'h7D, 8'hFF, 1'b1, 1'b1);
        check("push_used", used, 3);
        rd_check("push_7f", 7'h7F);
        rd_check("push_7e", 7'h7E);
        rd_check("push_7d", 7'h7D);
        check("push_7f_lit", data_out === 8'hFF ? 8'h05 : 8'h00, 8'h05);
        rd_check("push_00", 7'h00);

        // Pop, then a redundant pop
        wr(7'h7D, 8'h00, 1'b1, 1'b1);
        check("pop_used", used, 2);
        rd_check("pop_7d", 7'h7D);
        wr(7'h7D, 8'h00, 1'b1, 1'b1);
        check("pop2_used", used, 2);

        // Overwrite and select gating
        wr(7'h7E, 8'h33, 1'b1, 1'b1);
        check("ovw_used", used, 2);
        rd_check("ovw_7e", 7'h7E);
        wr(7'h7E, 8'h44, 1'b0, 1'b1);
        rd_check("cs_gate", 7'h7E);
        wr(7'h7E, 8'h44, 1'b1, 1'b0);
        rd_check("we_gate", 7'h7E);
        check("gate_used", used, 2);

        // Read shows old word until the edge of a same-address write
        address = 7'h7F;
        data_in = 8'h66;
        cs      = 1'b1;
        we      = 1'b1;
        #1;
        check("rbw_old", data_out, 8'h05);
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
        m_mem[7'h7F] = 8'h66;
        check("rbw_new", data_out, 8'h66);

        // Random traffic over a narrow address window so pops hit occupied words
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            d = ($urandom_range(0, 2) == 0) ? 8'h00 : DW'($urandom);
            c = ($urandom_range(0, 4) != 0);
            w = ($urandom_range(0, 4) != 0);
            wr(a, d, c, w);
            check("rnd_used", used, m_used());
            rd_check("rnd_rd", AW'($urandom_range(0, 1) == 0 ? int'(a) : int'($urandom_range(0, DEPTH - 1))));
        end

        // Mid-operation reset
        @(negedge clk);
        reset = 1'b0;
        #12;
        scrub(1'b0);
        wr(7'h01, 8'h11, 1'b1, 1'b1);
        wr(7'h02, 8'h22, 1'b1, 1'b1);
        wr(7'h03, 8'h33, 1'b1, 1'b1);
        check("mid_used3", used, 3);
        address = 7'h02;
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 1);
        check("mid_used", used, 0);
        check("mid_dout", data_out, 0);
        check("mid_rdv", rd_valid, 0);
        #10;
        scrub(1'b0);
        all_zero("mid_scrub");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_ram.md
# stack_ram

Memory-side responder for the stack calculator's data bus. It is a DEPTH×DW word store that the controller drives with `cs`, `we`, `address` and write data, and it returns read data combinationally. After every reset it scrubs the whole array to a fill value before it accepts any access. It also keeps a per-word occupancy bitmap, so the stack depth and the "was this word written" status are visible to the display and LED logic.

## Interface
- `DEPTH`, default 128: number of words.
- `AW`, default 7: address width; DEPTH == 2**AW.
- `DW`, default 8: data width.
- `FILL`, default 8'h00: value written to every word during the scrub.
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: one clock; reset is asynchronous and active-low.
- `cs` input 1: chip select; qualifies writes only.
- `we` input 1: write enable; a write occurs when `cs && we && !busy`.
- `address` input AW: word address for both read and write.
- `data_in` input DW: write data from the controller.
- `data_out` output DW: read data to the controller.
- `rd_valid` output 1: the word at `address` holds a nonzero value written since the scrub.
- `used` output AW+1: count of words whose valid bit is set (0..DEPTH).
- `busy` output 1: scrub in progress; all writes are ignored.

## Operation
- FSM states: INIT and READY. `reset` low forces INIT, scrub counter `scnt`=0, all valid bits=0, `used`=0. The array contents themselves are not reset.
- INIT:
  - Each edge writes FILL to mem[`scnt`] and increments `scnt`.
  - At the edge where `scnt`==DEPTH-1, the FSM writes the last word and moves to READY.
  - Controller writes are dropped during INIT.
- READY:
  - Reads are asynchronous: `data_out` = mem[`address`] whenever `address` changes, with no clock needed.
  - A write updates mem[`address`] on the edge where `cs && we` is true.
  - `cs` low or `we` low means no write. The read path is active regardless of `cs`, because the controller reads with `cs`=0.
- Valid bitmap update on each accepted write to address A with data D:
  - valid[A]=0, D≠0: set valid[A], `used`+1.
  - valid[A]=1, D=0: clear valid[A], `used`−1. This case matches a pop, which writes 0.
  - valid[A]=0 with D=0, or valid[A]=1 with D≠0: no change to the bitmap or `used`.
- `used` never wraps. By construction it stays within 0..DEPTH; an assertion checks this.
- `rd_valid` = valid[`address`], combinational.
- Width rules: `address` is used unmodified (no wrap logic inside the block). `data_in` is stored as-is, with no arithmetic.

## Timing
- Reset values:
  - `busy`=1, `used`=0, `rd_valid`=0.
  - `data_out`=0. `data_out` is forced to 0 whenever `busy`=1.
- Scrub length:
  - `busy` stays high for exactly DEPTH rising edges after `reset` deasserts (128 for defaults).
  - `busy` falls after the DEPTH-th edge.
  - The first accepted write is on edge DEPTH+1.
- Read latency: 0 cycles. `data_out` follows `address` in the same cycle. The controller samples it on the edge after it sets `address`.
- Write/read same address, same cycle: `data_out` shows the old word until the edge, then the new word.
- Bitmap and `used` update on the same edge as the array write. `rd_valid` reflects the new state in the cycle after the write.
- Reset asserted mid-scrub or mid-operation:
  - Immediate return to INIT with `busy`=1, `used`=0 and valid cleared, all asynchronously.
  - The scrub restarts at address 0 after release.
- Write coinciding with the final scrub edge (`scnt`=DEPTH-1): dropped, because `busy` is still 1 on that edge.

## Test plan
- **Scrub:** pre-load garbage, pulse `reset` low, release. Require `busy`=1 for exactly 128 edges, then every address reads 8'h00, `used`=0, `rd_valid`=0.
- **Push sequence:** after the scrub, write 8'h05 to 7'h7F, 8'h0A to 7'h7E, 8'hFF to 7'h7D. Require `used`=3, reads return 05/0A/FF, `rd_valid`=1 at those addresses and 0 at 7'h00.
- **Pop:** write 8'h00 to 7'h7D. Require `used`=2, read of 7'h7D = 00, `rd_valid`=0; then write 00 to 7'h7D again and require `used` still 2.
- **Overwrite and select gating:**
  - Write 8'h33 over valid 7'h7E: require `used` unchanged and read = 33.
  - Drive `we`=1 with `cs`=0 and data 8'h44: require no change.
- **Writes ignored while busy:** issue a write of 8'h77 to 7'h10 on scrub edges 5 and 128. Require 7'h10 reads 00 and `used`=0 after `busy` falls.
- **Mid-operation reset:** with `used`=3, assert `reset` low between edges. Require `busy`=1, `used`=0 and `data_out`=0 immediately; after release, a full 128-edge scrub, then all reads return 00.
